// File: rtl/countdown_timer_cla_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : countdown_timer_cla_pkg
//  Description : Shared definitions for the countdown timer: FSM state
//                encodings and default parameter values.
//  Revision    : 1.0 - initial release
// ============================================================================
package countdown_timer_cla_pkg;

    // Default instance geometry
    localparam int unsigned c_DEFAULT_WIDTH    = 4;
    localparam int unsigned c_DEFAULT_PRESCALE = 4;

    // FSM state encodings (explicit 1-bit width)
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

endpackage
`default_nettype wire

// File: rtl/countdown_timer_cla_sub_by_one_cla.sv
`default_nettype none
// ============================================================================
//  Module      : sub_by_one_cla
//  Description : Subtract-by-one implemented as a + {WIDTH{1'b1}} through a
//                flat carry-lookahead network. Carry-out is not produced.
//  Ports       : a    [WIDTH-1:0] in  - operand
//                diff [WIDTH-1:0] out - a - 1 (modulo 2^WIDTH)
//  Revision    : 1.0 - initial release
// ============================================================================
module sub_by_one_cla #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] diff
);

    // With b = all ones: generate g[j] = a[j] & 1 = a[j],
    // propagate p[k] = a[k] ^ 1 = ~a[k], carry-in = 0.
    // c[i] = OR over j<i of ( g[j] & AND over j<k<i of p[k] ).
    function automatic logic f_carry(input logic [WIDTH-1:0] op, input int i);
        logic acc;
        logic term;
        acc = 1'b0;
        for (int j = 0; j < WIDTH; j++) begin
            if (j < i) begin
                term = op[j];
                for (int k = 0; k < WIDTH; k++) begin
                    if ((k > j) && (k < i)) begin
                        term = term & ~op[k];
                    end
                end
                acc = acc | term;
            end
        end
        return acc;
    endfunction

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        if (i == 0) begin : g_lsb
            assign diff[i] = ~a[i];
        end else begin : g_upper
            // sum = a ^ b ^ c with b = 1
            assign diff[i] = ~a[i] ^ f_carry(a, i);
        end
    end

endmodule
`default_nettype wire

// File: rtl/countdown_timer_cla.sv
`default_nettype none
// ============================================================================
//  Module      : countdown_timer_cla
//  Description : Loadable, startable down-counter with prescaler, one-cycle
//                terminal-count pulse and optional auto-reload. Decrement uses
//                the carry-lookahead subtract-by-one datapath.
//  Ports       : clk         in  - system clock (rising edge)
//                rstn        in  - asynchronous active-low reset
//                load        in  - load load_value into count and reload reg
//                load_value  in  - value captured on load
//                start       in  - begin counting (IDLE, count != 0)
//                stop        in  - pause counting, count held
//                auto_reload in  - reload at terminal count and keep running
//                count       out - current count (registered)
//                busy        out - high in RUN (registered)
//                done        out - one-cycle terminal-count pulse (registered)
//  Revision    : 1.0 - initial release
// ============================================================================
module countdown_timer_cla
    import countdown_timer_cla_pkg::*;
#(
    parameter int unsigned WIDTH    = c_DEFAULT_WIDTH,
    parameter int unsigned PRESCALE = c_DEFAULT_PRESCALE
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             start,
    input  logic             stop,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done
);

    // Prescaler needs at least one bit even when PRESCALE == 1
    localparam int unsigned        c_PW        = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [c_PW-1:0]    c_PRESC_MAX = c_PW'(PRESCALE - 1);
    localparam logic [WIDTH-1:0]   c_ONE       = WIDTH'(1);

    logic [0:0]       r_state, w_state_nxt;
    logic [WIDTH-1:0] r_count, w_count_nxt;
    logic [WIDTH-1:0] r_reload, w_reload_nxt;
    logic [c_PW-1:0]  r_presc, w_presc_nxt;
    logic             r_done, w_done_nxt;

    logic [WIDTH-1:0] w_dec;
    logic             w_tick;

    sub_by_one_cla #(
        .WIDTH (WIDTH)
    ) u_sub (
        .a    (r_count),
        .diff (w_dec)
    );

    assign w_tick = (r_state == ST_RUN) && (r_presc == c_PRESC_MAX);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state  <= ST_IDLE;
            r_count  <= '0;
            r_reload <= '0;
            r_presc  <= '0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_count  <= w_count_nxt;
            r_reload <= w_reload_nxt;
            r_presc  <= w_presc_nxt;
            r_done   <= w_done_nxt;
        end
    end

    // Command priority: load > stop > start > tick
    always_comb begin
        w_state_nxt  = r_state;
        w_count_nxt  = r_count;
        w_reload_nxt = r_reload;
        w_presc_nxt  = r_presc;
        w_done_nxt   = 1'b0;

        if (load) begin
            w_count_nxt  = load_value;
            w_reload_nxt = load_value;
            w_state_nxt  = ST_IDLE;
            w_presc_nxt  = '0;
        end else if (stop) begin
            // A stop in IDLE is a no-op but still masks a coincident start
            if (r_state == ST_RUN) begin
                w_state_nxt = ST_IDLE;
                w_presc_nxt = '0;
            end
        end else if (r_state == ST_IDLE) begin
            if (start && (r_count != '0)) begin
                w_state_nxt = ST_RUN;
                w_presc_nxt = '0;
            end
        end else begin
            if (w_tick) begin
                w_presc_nxt = '0;
                // RUN is only entered with a nonzero count, so the terminal
                // case is count == 1 and the decrement never wraps
                if (r_count != c_ONE) begin
                    w_count_nxt = w_dec;
                end else begin
                    w_done_nxt = 1'b1;
                    if (auto_reload && (r_reload != '0)) begin
                        w_count_nxt = r_reload;
                    end else begin
                        w_count_nxt = '0;
                        w_state_nxt = ST_IDLE;
                    end
                end
            end else begin
                w_presc_nxt = r_presc + c_PW'(1);
            end
        end
    end

    assign count = r_count;
    assign busy  = r_state[0];
    assign done  = r_done;

endmodule
`default_nettype wire

// File: tb/tb_countdown_timer_cla.sv
`default_nettype none
// ============================================================================
//  Module      : tb_countdown_timer_cla
//  Description : Directed self-checking bench for countdown_timer_cla
//                (PRESCALE=4 and PRESCALE=1 instances sharing stimulus) and
//                sub_by_one_cla at WIDTH=4 and WIDTH=8.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_countdown_timer_cla;

    logic       clk = 1'b0;
    logic       rstn;
    logic       load;
    logic [3:0] load_value;
    logic       start;
    logic       stop;
    logic       auto_reload;

    logic [3:0] count4, count1;
    logic       busy4, busy1, done4, done1;

    logic [3:0] a4, d4;
    logic [7:0] a8, d8;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    countdown_timer_cla #(.WIDTH(4), .PRESCALE(4)) u_dut4 (
        .clk(clk), .rstn(rstn), .load(load), .load_value(load_value),
        .start(start), .stop(stop), .auto_reload(auto_reload),
        .count(count4), .busy(busy4), .done(done4)
    );

    countdown_timer_cla #(.WIDTH(4), .PRESCALE(1)) u_dut1 (
        .clk(clk), .rstn(rstn), .load(load), .load_value(load_value),
        .start(start), .stop(stop), .auto_reload(auto_reload),
        .count(count1), .busy(busy1), .done(done1)
    );

    sub_by_one_cla #(.WIDTH(4)) u_sub4 (.a(a4), .diff(d4));
    sub_by_one_cla #(.WIDTH(8)) u_sub8 (.a(a8), .diff(d8));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance n rising edges; sample point is 1 time unit after the edge
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin : main
        logic [3:0] ar_cnt [10];
        logic       ar_done[10];
        ar_cnt  = '{4'd4, 4'd3, 4'd2, 4'd1, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd5};
        ar_done = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

        rstn = 1'b0; load = 1'b0; load_value = '0; start = 1'b0;
        stop = 1'b0; auto_reload = 1'b0; a4 = '0; a8 = '0;

        // ---- reset values
        #12;
        check("rst_count", count4, 0);
        check("rst_busy",  busy4,  0);
        check("rst_done",  done4,  0);
        @(negedge clk);
        rstn = 1'b1;

        // ---- asynchronous reset mid-run
        load = 1'b1; load_value = 4'd9;
        step(1);
        check("load9_count", count4, 9);
        load = 1'b0; start = 1'b1;
        step(1);
        check("start_busy", busy4, 1);
        start = 1'b0;
        step(2);
        #2 rstn = 1'b0;
        #1;
        check("async_rst_count", count4, 0);
        check("async_rst_busy",  busy4,  0);
        check("async_rst_done",  done4,  0);
        #2 rstn = 1'b1;

        // ---- one-shot, PRESCALE=4, load 3
        step(1);
        load = 1'b1; load_value = 4'd3;
        step(1);
        load = 1'b0; start = 1'b1;
        step(1);                                   // edge k
        start = 1'b0;
        check("os_k_busy",  busy4,  1);
        check("os_k_count", count4, 3);
        step(3);
        check("os_k3_count", count4, 3);
        step(1);
        check("os_k4_count", count4, 2);
        step(4);
        check("os_k8_count", count4, 1);
        step(3);
        check("os_k11_done", done4, 0);
        check("os_k11_busy", busy4, 1);
        step(1);
        check("os_k12_count", count4, 0);
        check("os_k12_busy",  busy4,  0);
        check("os_k12_done",  done4,  1);
        step(1);
        check("os_k13_done", done4, 0);

        // ---- auto-reload, PRESCALE=1, load 5
        auto_reload = 1'b1;
        load = 1'b1; load_value = 4'd5;
        step(1);
        load = 1'b0; start = 1'b1;
        step(1);
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            check($sformatf("ar_count_%0d", i), count1, ar_cnt[i]);
            check($sformatf("ar_done_%0d", i),  done1,  ar_done[i]);
            check($sformatf("ar_busy_%0d", i),  busy1,  1);
        end
        auto_reload = 1'b0;
        load = 1'b1; load_value = 4'd0;
        step(1);
        load = 1'b0;

        // ---- stop / resume, PRESCALE=4, load 7
        load = 1'b1; load_value = 4'd7;
        step(1);
        load = 1'b0; start = 1'b1;
        step(1);
        start = 1'b0;
        step(8);
        check("sr_after2_count", count4, 5);
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        check("sr_stop_busy",  busy4,  0);
        check("sr_stop_count", count4, 5);
        step(5);
        check("sr_held_count", count4, 5);
        start = 1'b1;
        step(1);
        start = 1'b0;
        check("sr_restart_busy", busy4, 1);
        step(3);
        check("sr_k3_count", count4, 5);
        step(1);
        check("sr_k4_count", count4, 4);

        // ---- load beats stop and start
        load = 1'b1; stop = 1'b1; start = 1'b1; load_value = 4'd10;
        step(1);
        load = 1'b0; stop = 1'b0; start = 1'b0;
        check("pri_load_count", count4, 10);
        check("pri_load_busy",  busy4,  0);
        step(1);
        check("pri_load_idle", busy4, 0);

        // ---- load coincident with terminal tick
        load = 1'b1; load_value = 4'd1;
        step(1);
        load = 1'b0; start = 1'b1;
        step(1);
        start = 1'b0;
        step(3);
        load = 1'b1; load_value = 4'd6;
        step(1);                                   // would be terminal edge
        load = 1'b0;
        check("lt_count", count4, 6);
        check("lt_busy",  busy4,  0);
        check("lt_done",  done4,  0);
        step(1);
        check("lt_done_next", done4, 0);

        // ---- start with count 0 is ignored
        load = 1'b1; load_value = 4'd0;
        step(1);
        load = 1'b0; start = 1'b1;
        step(1);
        start = 1'b0;
        check("z_busy",  busy4,  0);
        check("z_count", count4, 0);
        step(1);
        check("z_done", done4, 0);

        // ---- CLA subtract-by-one, exhaustive at WIDTH 4 and 8
        for (int v = 0; v < 16; v++) begin
            logic [3:0] e4;
            a4 = 4'(v);
            e4 = 4'(v + 15);
            #1;
            check($sformatf("cla4_%0d", v), d4, e4);
        end
        for (int v = 0; v < 256; v++) begin
            logic [7:0] e8;
            a8 = 8'(v);
            e8 = 8'(v + 255);
            #1;
            check($sformatf("cla8_%0d", v), d8, e8);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
